// File: rtl/dmac_pkg.sv
// Shared encodings and sizing for the single-channel DMA controller.
package dmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;
  localparam logic STEP_INC    = 1'b0;
  localparam logic STEP_DEC    = 1'b1;

  localparam int CHUNK_WORDS_DEF = 16;
  localparam int WCNT_W          = 17;  // holds 65536
  localparam int CHUNK_W         = 9;   // holds 256

  function automatic logic [CHUNK_W-1:0] chunk_len(input logic [WCNT_W-1:0] remaining,
                                                   input int chunk_words);
    if (remaining > WCNT_W'(chunk_words)) return CHUNK_W'(chunk_words);
    else return remaining[CHUNK_W-1:0];
  endfunction

endpackage

// File: rtl/dmac_ch_addr.sv
// Address generator plus remaining-word and per-chunk counters for one DMA channel.
module dmac_ch_addr
  import dmac_pkg::*;
#(
  parameter int CHUNK_WORDS = CHUNK_WORDS_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [31:0] i_madr,
  input  logic [15:0] i_bcr,
  input  logic        i_step,
  input  logic        i_adv,
  output logic [31:0] o_addr,
  output logic        o_last_word,
  output logic        o_last_chunk_word
);

  logic [31:0]        r_addr;
  logic               r_step;
  logic [WCNT_W-1:0]  r_remain;
  logic [CHUNK_W-1:0] r_chunk;
  logic [WCNT_W-1:0]  w_load_cnt;
  logic [WCNT_W-1:0]  w_remain_nxt;

  assign w_load_cnt   = (i_bcr == 16'd0) ? WCNT_W'(65536) : {1'b0, i_bcr};
  assign w_remain_nxt = r_remain - WCNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_step   <= STEP_INC;
      r_remain <= '0;
      r_chunk  <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_addr   <= i_madr;
        r_step   <= i_step;
        r_remain <= w_load_cnt;
        r_chunk  <= chunk_len(w_load_cnt, CHUNK_WORDS);
      end else if (i_adv) begin
        r_addr   <= (r_step == STEP_DEC) ? r_addr - 32'd4 : r_addr + 32'd4;
        r_remain <= w_remain_nxt;
        // Reload the chunk budget as the current chunk retires its last word
        r_chunk  <= o_last_chunk_word ? chunk_len(w_remain_nxt, CHUNK_WORDS)
                                      : r_chunk - CHUNK_W'(1);
      end
    end
  end

  assign o_addr            = r_addr;
  assign o_last_word       = (r_remain == WCNT_W'(1));
  assign o_last_chunk_word = (r_chunk == CHUNK_W'(1));

endmodule

// File: rtl/dmac_ch.sv
// Single DMA channel: arbitrates per chunk, then streams words over a Wishbone master port.
// Optional sticky completion interrupt is built when DMAC_CH_IRQ_EN is defined.
module dmac_ch
  import dmac_pkg::*;
#(
  parameter int CHUNK_WORDS = CHUNK_WORDS_DEF
) (
  input  logic        CLK,
  input  logic        RST_ASYNC_N,
  input  logic        EN,
  input  logic        START_IN,
  input  logic [31:0] MADR_IN,
  input  logic [15:0] BCR_IN,
  input  logic        DIR_IN,
  input  logic        STEP_IN,
  input  logic        DREQ_IN,
  output logic        DMAC_REQ_OUT,
  input  logic        DMAC_CH_SEL_IN,
  output logic        DMAC_ACK_OUT,
  output logic        BUS_LAST_ACK_OUT,
  output logic        WB_CYC_OUT,
  output logic        WB_STB_OUT,
  output logic        WB_WE_OUT,
  output logic [31:0] WB_ADR_OUT,
  output logic [31:0] WB_DAT_OUT,
  input  logic [31:0] WB_DAT_IN,
  input  logic        WB_ACK_IN,
  input  logic [31:0] DEV_DAT_IN,
  output logic        DEV_RD_OUT,
  output logic [31:0] DEV_DAT_OUT,
  output logic        DEV_WR_OUT,
  output logic        BUSY_OUT,
  output logic        DONE_OUT,
  output logic        IRQ_OUT,
  input  logic        IRQ_CLR_IN
);

  state_e      r_state;
  logic        r_dir;
  logic        r_dev_wr;
  logic [31:0] r_dev_dat;
  logic        w_xfer;
  logic        w_ack;
  logic        w_load;
  logic        w_go;
  logic        w_last_word;
  logic        w_last_chunk;
  logic [31:0] w_addr;

  assign w_xfer = (r_state == ST_XFER);
  assign w_ack  = w_xfer & WB_ACK_IN & EN;
  assign w_load = (r_state == ST_IDLE) & START_IN;
  assign w_go   = DMAC_CH_SEL_IN & DREQ_IN;

  dmac_ch_addr #(.CHUNK_WORDS(CHUNK_WORDS)) u_addr (
    .i_clk             (CLK),
    .i_rst_n           (RST_ASYNC_N),
    .i_en              (EN),
    .i_load            (w_load),
    .i_madr            (MADR_IN),
    .i_bcr             (BCR_IN),
    .i_step            (STEP_IN),
    .i_adv             (w_ack),
    .o_addr            (w_addr),
    .o_last_word       (w_last_word),
    .o_last_chunk_word (w_last_chunk)
  );

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      r_state   <= ST_IDLE;
      r_dir     <= DIR_DEV2MEM;
      r_dev_wr  <= 1'b0;
      r_dev_dat <= '0;
    end else if (EN) begin
      r_dev_wr <= w_ack & (r_dir == DIR_MEM2DEV);
      if (w_ack && (r_dir == DIR_MEM2DEV)) r_dev_dat <= WB_DAT_IN;
      case (r_state)
        ST_IDLE: if (START_IN) begin
          r_state <= ST_REQ;
          r_dir   <= DIR_IN;
        end
        ST_REQ:  if (w_go) r_state <= ST_XFER;
        // A dropped grant mid-chunk is not honoured; the word in flight still completes
        ST_XFER: if (w_ack && w_last_chunk) r_state <= w_last_word ? ST_DONE : ST_GAP;
        ST_GAP:  r_state <= w_go ? ST_XFER : ST_REQ;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DMAC_REQ_OUT     = ((r_state == ST_REQ) & DREQ_IN) | (r_state == ST_GAP);
  assign DMAC_ACK_OUT     = w_xfer;
  assign WB_CYC_OUT       = w_xfer;
  assign WB_STB_OUT       = w_xfer;
  assign WB_WE_OUT        = w_xfer & (r_dir == DIR_DEV2MEM);
  assign WB_ADR_OUT       = w_addr;
  assign WB_DAT_OUT       = (w_xfer && (r_dir == DIR_DEV2MEM)) ? DEV_DAT_IN : 32'd0;
  assign DEV_RD_OUT       = w_ack & (r_dir == DIR_DEV2MEM);
  assign BUS_LAST_ACK_OUT = w_ack & w_last_chunk;
  assign DEV_DAT_OUT      = r_dev_dat;
  assign DEV_WR_OUT       = r_dev_wr;
  assign BUSY_OUT         = (r_state != ST_IDLE);
  assign DONE_OUT         = (r_state == ST_DONE);

`ifdef DMAC_CH_IRQ_EN
  logic r_irq;

  // Set has priority so a clear landing on the completion cycle cannot lose the event
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) r_irq <= 1'b0;
    else if (EN) begin
      if (r_state == ST_DONE) r_irq <= 1'b1;
      else if (IRQ_CLR_IN)    r_irq <= 1'b0;
    end
  end

  assign IRQ_OUT = r_irq;
`else
  logic w_unused_irq_clr;

  assign w_unused_irq_clr = IRQ_CLR_IN;
  assign IRQ_OUT          = 1'b0;
`endif

endmodule

// File: tb/tb_dmac_ch.sv
// Bench for dmac_ch: directed and randomized transfers against a word-level reference model.
module tb_dmac_ch;

  localparam int CHUNK = 16;
`ifdef DMAC_CH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        CLK, RST_ASYNC_N, EN, START_IN, DIR_IN, STEP_IN, DREQ_IN, DMAC_CH_SEL_IN;
  logic [31:0] MADR_IN, WB_DAT_IN, DEV_DAT_IN;
  logic [15:0] BCR_IN;
  logic        WB_ACK_IN, IRQ_CLR_IN;
  logic        DMAC_REQ_OUT, DMAC_ACK_OUT, BUS_LAST_ACK_OUT, WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT;
  logic [31:0] WB_ADR_OUT, WB_DAT_OUT, DEV_DAT_OUT;
  logic        DEV_RD_OUT, DEV_WR_OUT, BUSY_OUT, DONE_OUT, IRQ_OUT;

  int checks = 0;
  int failures = 0;

  dmac_ch #(.CHUNK_WORDS(CHUNK)) dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .EN(EN), .START_IN(START_IN),
    .MADR_IN(MADR_IN), .BCR_IN(BCR_IN), .DIR_IN(DIR_IN), .STEP_IN(STEP_IN),
    .DREQ_IN(DREQ_IN), .DMAC_REQ_OUT(DMAC_REQ_OUT), .DMAC_CH_SEL_IN(DMAC_CH_SEL_IN),
    .DMAC_ACK_OUT(DMAC_ACK_OUT), .BUS_LAST_ACK_OUT(BUS_LAST_ACK_OUT),
    .WB_CYC_OUT(WB_CYC_OUT), .WB_STB_OUT(WB_STB_OUT), .WB_WE_OUT(WB_WE_OUT),
    .WB_ADR_OUT(WB_ADR_OUT), .WB_DAT_OUT(WB_DAT_OUT), .WB_DAT_IN(WB_DAT_IN),
    .WB_ACK_IN(WB_ACK_IN), .DEV_DAT_IN(DEV_DAT_IN), .DEV_RD_OUT(DEV_RD_OUT),
    .DEV_DAT_OUT(DEV_DAT_OUT), .DEV_WR_OUT(DEV_WR_OUT), .BUSY_OUT(BUSY_OUT),
    .DONE_OUT(DONE_OUT), .IRQ_OUT(IRQ_OUT), .IRQ_CLR_IN(IRQ_CLR_IN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {21'd0, DMAC_REQ_OUT, DMAC_ACK_OUT, BUS_LAST_ACK_OUT, WB_CYC_OUT,
                        WB_STB_OUT, WB_WE_OUT, DEV_RD_OUT, DEV_WR_OUT, BUSY_OUT, DONE_OUT,
                        IRQ_OUT}, 32'd0);
    chk({tag, "_adr"}, WB_ADR_OUT, 32'd0);
    chk({tag, "_wdat"}, WB_DAT_OUT, 32'd0);
    chk({tag, "_ddat"}, DEV_DAT_OUT, 32'd0);
  endtask

  // mode 0: grant/dreq always on, every cycle acked; mode 1: random handshakes and
  // spurious START pulses; mode 2: grant withheld on each inter-chunk gap cycle.
  task automatic run_xfer(input logic [31:0] madr, input int bcr, input logic dir,
                          input logic step, input int mode);
    int n, k, lastacks;
    bit in_chunk, gap, done_next, wr_pend, ack, grant, dreq, fin, last;
    logic [31:0] wr_dat, exp_adr, bus_d, dev_d;
    n = (bcr == 0) ? 65536 : bcr;
    k = 0; lastacks = 0; in_chunk = 0; gap = 0; done_next = 0; wr_pend = 0; fin = 0;
    wr_dat = '0;
    MADR_IN = madr; BCR_IN = 16'(bcr); DIR_IN = dir; STEP_IN = step; START_IN = 1'b1;
    WB_ACK_IN = 1'b0; DMAC_CH_SEL_IN = 1'b0; DREQ_IN = 1'b0;
    #1;
    chk("idle_busy", {31'd0, BUSY_OUT}, 32'd0);
    @(posedge CLK); #1;
    START_IN = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      chk("cyc", {31'd0, WB_CYC_OUT}, {31'd0, in_chunk});
      chk("dev_wr", {31'd0, DEV_WR_OUT}, {31'd0, wr_pend});
      if (wr_pend) chk("dev_dat", DEV_DAT_OUT, wr_dat);
      wr_pend = 0;
      if (done_next) begin
        chk("done", {31'd0, DONE_OUT}, 32'd1);
        chk("done_busy", {31'd0, BUSY_OUT}, 32'd1);
        chk("done_req", {31'd0, DMAC_REQ_OUT}, 32'd0);
        chk("last_ack_count", lastacks, (n + CHUNK - 1) / CHUNK);
        START_IN = 1'b0; IRQ_CLR_IN = 1'b1; WB_ACK_IN = 1'b0;
        DMAC_CH_SEL_IN = 1'b0; DREQ_IN = 1'b0;
        @(posedge CLK); #1;
        chk("done_pulse", {31'd0, DONE_OUT}, 32'd0);
        chk("end_busy", {31'd0, BUSY_OUT}, 32'd0);
        chk("irq_set", {31'd0, IRQ_OUT}, {31'd0, IRQ_EN});
        @(posedge CLK); #1;
        IRQ_CLR_IN = 1'b0;
        chk("irq_clr", {31'd0, IRQ_OUT}, 32'd0);
        fin = 1;
      end else begin
        START_IN = (mode == 1) && ($urandom % 6 == 0);
        if (START_IN) MADR_IN = $urandom;
        if (in_chunk) begin
          ack = (mode == 0) ? 1'b1 : ($urandom % 3 != 0);
          grant = 1'b1;
          dreq = ($urandom % 2 == 1);
        end else begin
          ack = 1'b0;
          case (mode)
            0: begin grant = 1'b1; dreq = 1'b1; end
            2: begin grant = !gap; dreq = 1'b1; end
            default: begin grant = ($urandom % 4 != 0); dreq = ($urandom % 4 != 0); end
          endcase
        end
        bus_d = $urandom; dev_d = $urandom;
        WB_ACK_IN = ack; DMAC_CH_SEL_IN = grant; DREQ_IN = dreq;
        WB_DAT_IN = bus_d; DEV_DAT_IN = dev_d;
        #1;
        chk("busy", {31'd0, BUSY_OUT}, 32'd1);
        chk("done_lo", {31'd0, DONE_OUT}, 32'd0);
        if (in_chunk) begin
          exp_adr = step ? madr - 32'(4 * k) : madr + 32'(4 * k);
          chk("adr", WB_ADR_OUT, exp_adr);
          chk("we", {31'd0, WB_WE_OUT}, {31'd0, !dir});
          chk("stb", {31'd0, WB_STB_OUT}, 32'd1);
          chk("ch_ack", {31'd0, DMAC_ACK_OUT}, 32'd1);
          chk("req_xfer", {31'd0, DMAC_REQ_OUT}, 32'd0);
          chk("dev_rd", {31'd0, DEV_RD_OUT}, {31'd0, ack && !dir});
          if (!dir) chk("wdat", WB_DAT_OUT, dev_d);
          last = ack && ((((k + 1) % CHUNK) == 0) || (k + 1 == n));
          chk("last_ack", {31'd0, BUS_LAST_ACK_OUT}, {31'd0, last});
          if (ack) begin
            if (dir) begin wr_pend = 1; wr_dat = bus_d; end
            k++;
            if (last) begin
              lastacks++;
              in_chunk = 0;
              if (k == n) done_next = 1;
              else gap = 1;
            end
          end
        end else begin
          chk("req", {31'd0, DMAC_REQ_OUT}, {31'd0, gap ? 1'b1 : dreq});
          chk("last_idle", {31'd0, BUS_LAST_ACK_OUT}, 32'd0);
          chk("rd_idle", {31'd0, DEV_RD_OUT}, 32'd0);
          in_chunk = grant && dreq;
          gap = 0;
        end
        @(posedge CLK); #1;
      end
    end
    chk("finished", {31'd0, fin}, 32'd1);
    START_IN = 1'b0; WB_ACK_IN = 1'b0; DMAC_CH_SEL_IN = 1'b0; DREQ_IN = 1'b0;
  endtask

  initial begin
    RST_ASYNC_N = 1'b0; EN = 1'b1; START_IN = 1'b0; MADR_IN = '0; BCR_IN = '0;
    DIR_IN = 1'b0; STEP_IN = 1'b0; DREQ_IN = 1'b0; DMAC_CH_SEL_IN = 1'b0;
    WB_DAT_IN = '0; WB_ACK_IN = 1'b0; DEV_DAT_IN = '0; IRQ_CLR_IN = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge CLK); #1;
    RST_ASYNC_N = 1'b1;
    @(posedge CLK); #1;

    // Clock enable low: a START must not be taken
    EN = 1'b0; MADR_IN = 32'h100; BCR_IN = 16'd2; START_IN = 1'b1;
    @(posedge CLK); #1;
    START_IN = 1'b0;
    chk("en_hold", {31'd0, BUSY_OUT}, 32'd0);
    EN = 1'b1;
    @(posedge CLK); #1;

    run_xfer(32'h0000_1000, 4, 1'b0, 1'b0, 0);
    run_xfer(32'h0000_2000, 20, 1'b0, 1'b0, 2);
    run_xfer(32'h0000_0004, 3, 1'b1, 1'b1, 0);

    // Reset asserted while a bus cycle is outstanding
    MADR_IN = 32'h0000_3000; BCR_IN = 16'd8; DIR_IN = 1'b0; STEP_IN = 1'b0;
    DMAC_CH_SEL_IN = 1'b1; DREQ_IN = 1'b1; START_IN = 1'b1;
    @(posedge CLK); #1;
    START_IN = 1'b0;
    for (int i = 0; i < 10 && !WB_STB_OUT; i++) begin
      @(posedge CLK); #1;
    end
    chk("rst_pre_stb", {31'd0, WB_STB_OUT}, 32'd1);
    WB_ACK_IN = 1'b1; DEV_DAT_IN = 32'hFFFF_FFFF;
    #1;
    RST_ASYNC_N = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    WB_ACK_IN = 1'b0; DMAC_CH_SEL_IN = 1'b0; DREQ_IN = 1'b0;
    @(posedge CLK); #1;
    RST_ASYNC_N = 1'b1;
    @(posedge CLK); #1;
    run_xfer(32'h0000_0800, 5, 1'b1, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      run_xfer($urandom & 32'hFFFF_FFFC, int'($urandom_range(1, 40)),
               ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmac_ch.md
DMAC_CH -- requirements
Module: dmac_ch

Interface
REQ-001 Parameter: CHUNK_WORDS, 16, words per arbitration chunk; legal range 1..256.
REQ-002 CLK  in  1  single clock; all flops rising-edge.
REQ-003 RST_ASYNC_N  in  1  reset, asynchronous assert, active-low.
REQ-004 EN  in  1  clock enable; all state holds when low.
REQ-005 START_IN  in  1  one-cycle start pulse; samples MADR_IN, BCR_IN, DIR_IN, STEP_IN.
REQ-006 MADR_IN  in  32  start memory byte address, word aligned.
REQ-007 BCR_IN  in  16  word count; 0 means 65536.
REQ-008 DIR_IN  in  1  0 = device-to-memory (bus write), 1 = memory-to-device (bus read).
REQ-009 STEP_IN  in  1  0 = address +4 per word, 1 = address -4 per word.
REQ-010 DREQ_IN  in  1  peripheral ready for a chunk.
REQ-011 DMAC_REQ_OUT  out  1  arbitration request to the channel arbiter.
REQ-012 DMAC_CH_SEL_IN  in  1  this channel's grant bit from the arbiter.
REQ-013 DMAC_ACK_OUT  out  1  bus cycle in progress (CYC high).
REQ-014 BUS_LAST_ACK_OUT  out  1  high during the WB_ACK_IN cycle of a chunk's final word.
REQ-015 WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT  out  1 each  bus master controls.
REQ-016 WB_ADR_OUT  out  32; WB_DAT_OUT  out  32; WB_DAT_IN  in  32; WB_ACK_IN  in  1.
REQ-017 DEV_DAT_IN  in  32; DEV_RD_OUT  out  1 (pop); DEV_DAT_OUT  out  32; DEV_WR_OUT  out  1 (push).
REQ-018 BUSY_OUT  out  1; DONE_OUT  out  1 (one-cycle pulse); IRQ_OUT  out  1; IRQ_CLR_IN  in  1.

Function
REQ-019 States: IDLE, REQ, XFER, GAP, DONE.
REQ-020 IDLE: START_IN latches config into address register, remaining count (BCR_IN=0 loads 65536), and chunk counter = min(CHUNK_WORDS, remaining); next state REQ; START_IN in any other state is ignored.
REQ-021 REQ: DMAC_REQ_OUT = DREQ_IN; DMAC_CH_SEL_IN & DREQ_IN -> XFER next cycle.
REQ-022 XFER: CYC/STB high continuously, WE = ~DIR, ADR = current address; each WB_ACK_IN advances address by ±4 (mod 2^32), decrements remaining and chunk count; next word presented the following cycle.
REQ-023 DIR=0: WB_DAT_OUT = DEV_DAT_IN combinationally; DEV_RD_OUT = WB_ACK_IN during XFER.
REQ-024 DIR=1: on WB_ACK_IN, DEV_DAT_OUT <= WB_DAT_IN and DEV_WR_OUT pulses the next cycle.
REQ-025 Chunk-final ack: BUS_LAST_ACK_OUT high same cycle; CYC/STB drop next cycle; remaining = 0 -> DONE, else -> GAP with chunk count reloaded.
REQ-026 GAP (exactly one cycle, DMAC_REQ_OUT held high): DMAC_CH_SEL_IN & DREQ_IN -> XFER, else REQ (preempted or device stalled).
REQ-027 DREQ_IN is sampled only at chunk start; deassertion mid-chunk does not stall the chunk.
REQ-028 DMAC_CH_SEL_IN deasserting in XFER is a protocol error; channel completes the outstanding word regardless.
REQ-029 DONE: DONE_OUT pulses one cycle, DMAC_REQ_OUT low, -> IDLE; BUSY_OUT high in all states except IDLE.
REQ-030 DMAC_REQ_OUT is low in IDLE, XFER, and DONE.

Reset
REQ-031 RST_ASYNC_N low: state IDLE; all outputs 0; address, counts, and IRQ flag 0; takes effect mid-transfer without completing the bus cycle.

Configuration
REQ-032 DMAC_CH_IRQ_EN defined: IRQ_OUT is a sticky flag set on the DONE cycle and cleared by IRQ_CLR_IN; set wins on a simultaneous clear.
REQ-033 DMAC_CH_IRQ_EN undefined: IRQ_OUT is tied 0, IRQ_CLR_IN is ignored, and no IRQ flop exists.

Structure
REQ-034 Package dmac_pkg holds: state encoding, DIR/STEP encodings, CHUNK_WORDS default, and word-count width constant.
REQ-035 One sub-module, dmac_ch_addr, holds the address register, step logic, remaining counter, and chunk counter, and outputs last_word and last_chunk_word flags.

Verification
REQ-036 MADR=0x1000, BCR=4, DIR=0, STEP=0, CHUNK=16, constant grant -> writes to 0x1000, 0x1004, 0x1008, 0x100C; one BUS_LAST_ACK on the 4th ack; DONE_OUT pulses.
REQ-037 BCR=20, CHUNK=16 -> 16 words, then GAP; grant withdrawn in GAP -> REQ; regrant -> 4 more words; 2 BUS_LAST_ACK pulses total.
REQ-038 MADR=0x4, STEP=1, BCR=3, DIR=1 -> reads 0x4, 0x0, 0xFFFFFFFC; DEV_WR_OUT pulses carry WB_DAT_IN values in order.
REQ-039 RST_ASYNC_N low while WB_STB is high -> all outputs 0 asynchronously; after release, START_IN is accepted normally.
REQ-040 With DMAC_CH_IRQ_EN defined, IRQ_CLR_IN coincident with the DONE cycle -> IRQ_OUT = 1; without the macro, IRQ_OUT stays 0.
